// File: rtl/mac_accum_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : mac_seq_pkg                                                  |
// | Purpose   : Shared types and constants for the MAC accumulate sequencer: |
// |             FSM state encoding, datapath/counter widths and the          |
// |             saturation value.                                            |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package mac_seq_pkg;

  localparam int MAC_W     = 12;
  localparam int MAC_LEN_W = 4;

  // Clamp value that the accumulator takes on carry-out when saturation is built in.
  localparam logic [MAC_W-1:0] ACC_SAT = {MAC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : mac_seq_pkg
`default_nettype wire

// File: rtl/mac_accum_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : mac_accum_sequencer_if                                       |
// | Purpose   : Bundles the command, operand-beat and result handshakes of   |
// |             the MAC accumulate sequencer.                                |
// |   master  : drives start/len, in_valid/in_a/in_b, out_ready              |
// |   slave   : drives in_ready, out_valid/out_sum/out_ovf, busy             |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface mac_accum_sequencer_if
  import mac_seq_pkg::*;
#(
  parameter int W     = MAC_W,
  parameter int LEN_W = MAC_LEN_W
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface : mac_accum_sequencer_if
`default_nettype wire

// File: rtl/mac_accum_sequencer_add3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : reversible_12bit_adder                                       |
// | Purpose   : Combinational three-operand adder, sum = a + b + c mod 2**W. |
// |   a, b, c : W-bit operands                                               |
// |   sum     : W-bit wrapped sum                                            |
// |   carry   : 1 when the true sum does not fit in W bits                   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module reversible_12bit_adder
  import mac_seq_pkg::*;
#(
  parameter int W = MAC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic         carry
);

  // Three W-bit operands need two extra bits; either one set means overflow.
  logic [W+1:0] w_full;

  always_comb begin
    w_full = {2'b00, a} + {2'b00, b} + {2'b00, c};
    sum    = w_full[W-1:0];
    carry  = |w_full[W+1:W];
  end

endmodule : reversible_12bit_adder
`default_nettype wire

// File: rtl/mac_accum_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : mac_accum_sequencer                                          |
// | Purpose   : Runs bursts of operand pairs through a three-operand adder,  |
// |             acc <= acc + in_a + in_b, one beat per cycle, and presents   |
// |             the final sum plus a sticky overflow flag on a valid/ready   |
// |             result port.                                                 |
// | Ports     : clk, rst (sync, active-high)                                 |
// |             bus.slave : start/len, in_valid/in_ready/in_a/in_b,          |
// |                         out_valid/out_ready/out_sum/out_ovf, busy        |
// | Options   : MAC_ACC_SATURATE_EN - clamp acc to all-ones on carry-out     |
// |             (default: wrap modulo 2**W; ovf is set either way)           |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module mac_accum_sequencer
  import mac_seq_pkg::*;
#(
  parameter int W     = MAC_W,
  parameter int LEN_W = MAC_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_accum_sequencer_if.slave  bus
);

  localparam logic [LEN_W-1:0] C_ONE = LEN_W'(1);

  state_t           r_state;
  logic [W-1:0]     r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_out_sum;
  logic             r_out_ovf;
  logic             r_busy;

  logic [W-1:0]     w_sum;
  logic             w_carry;
  logic [W-1:0]     w_acc_next;
  logic             w_ovf_next;
  logic             w_beat;
  logic             w_last;

  reversible_12bit_adder #(.W(W)) u_add3 (
    .a     (r_acc),
    .b     (bus.in_a),
    .c     (bus.in_b),
    .sum   (w_sum),
    .carry (w_carry)
  );

  always_comb begin
    w_beat     = bus.in_valid && r_in_ready;
    w_last     = (r_cnt == (r_len_q - C_ONE));
    w_ovf_next = r_ovf | w_carry;
`ifdef MAC_ACC_SATURATE_EN
    w_acc_next = w_carry ? ACC_SAT : w_sum;
`else
    w_acc_next = w_sum;
`endif
  end

  // Outputs are registered next to the state so they change exactly with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_len_q <= bus.len;
            r_busy  <= 1'b1;
            if (bus.len != '0) begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              // Empty burst: result is zero, presented the next cycle.
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_out_sum   <= '0;
              r_out_ovf   <= 1'b0;
            end
          end
        end

        ACCUM: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            r_ovf <= w_ovf_next;
            r_cnt <= r_cnt + C_ONE;
            if (w_last) begin
              // Forward the just-computed values so out_valid rises one cycle after the beat.
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_acc_next;
              r_out_ovf   <= w_ovf_next;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.busy      = r_busy;

endmodule : mac_accum_sequencer
`default_nettype wire

// File: tb/tb_mac_accum_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_mac_accum_sequencer                                       |
// | Purpose   : Directed self-checking bench for mac_accum_sequencer with    |
// |             hand-computed expected values.                               |
// | Options   : MAC_ACC_SATURATE_EN selects the clamped expectation.         |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mac_accum_sequencer;
  import mac_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mac_accum_sequencer_if #(.W(MAC_W), .LEN_W(MAC_LEN_W)) bus ();

  mac_accum_sequencer #(.W(MAC_W), .LEN_W(MAC_LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [MAC_LEN_W-1:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  task automatic beat(input logic [MAC_W-1:0] a, input logic [MAC_W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [MAC_W-1:0] exp_sat;
  logic [MAC_W-1:0] held_sum;

  initial begin
    n_chk = 0;
    n_err = 0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
    chk("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);

    // 1: len=3, 1+2+3+4+5+6 = 21
    do_start(4'd3);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t1_busy",     32'(bus.busy),     32'd1);
    beat(12'd1, 12'd2);
    beat(12'd3, 12'd4);
    chk("t1_not_done", 32'(bus.out_valid), 32'd0);
    beat(12'd5, 12'd6);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_in_ready0", 32'(bus.in_ready),  32'd0);
    chk("t1_sum",       32'(bus.out_sum),   32'd21);
    chk("t1_ovf",       32'(bus.out_ovf),   32'd0);
    handshake();
    chk("t1_idle_busy",  32'(bus.busy),      32'd0);
    chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);

    // 2: 0x800+0x700 = 0xF00, then 0xF00+0x100 carries out
`ifdef MAC_ACC_SATURATE_EN
    exp_sat = 12'hFFF;
`else
    exp_sat = 12'h000;
`endif
    do_start(4'd2);
    beat(12'h800, 12'h700);
    beat(12'h100, 12'h000);
    chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_sum",       32'(bus.out_sum),   32'(exp_sat));
    chk("t2_ovf",       32'(bus.out_ovf),   32'd1);
    handshake();

    // 3: len=0 -> zero result next cycle, no beats consumed
    do_start(4'd0);
    chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_in_ready",  32'(bus.in_ready),  32'd0);
    chk("t3_sum",       32'(bus.out_sum),   32'd0);
    chk("t3_ovf",       32'(bus.out_ovf),   32'd0);
    handshake();
    chk("t3_idle", 32'(bus.busy), 32'd0);

    // 4: gaps between beats, consumer stalls for 4 cycles; 10+20+30+40 = 100
    do_start(4'd2);
    beat(12'd10, 12'd20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_gap_ready", 32'(bus.in_ready),  32'd1);
      chk("t4_gap_valid", 32'(bus.out_valid), 32'd0);
    end
    beat(12'd30, 12'd40);
    held_sum = 12'd100;
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_sum",   32'(bus.out_sum),   32'(held_sum));
      chk("t4_hold_busy",  32'(bus.busy),      32'd1);
      tick();
    end
    handshake();
    chk("t4_idle", 32'(bus.busy), 32'd0);

    // 5: reset mid-burst, then a fresh len=1 burst of (7,8)
    do_start(4'd4);
    beat(12'd100, 12'd200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy",  32'(bus.busy),      32'd0);
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready),  32'd0);
    do_start(4'd1);
    beat(12'd7, 12'd8);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_sum",       32'(bus.out_sum),   32'd15);
    chk("t5_ovf",       32'(bus.out_ovf),   32'd0);
    handshake();

    // 6: start during ACCUM and in the DONE handshake cycle are ignored; 2+4+6 = 12
    do_start(4'd3);
    beat(12'd1, 12'd1);
    do_start(4'd1);
    chk("t6_still_accum", 32'(bus.in_ready),  32'd1);
    chk("t6_no_done",     32'(bus.out_valid), 32'd0);
    beat(12'd2, 12'd2);
    chk("t6_len_kept", 32'(bus.out_valid), 32'd0);
    beat(12'd3, 12'd3);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_sum",       32'(bus.out_sum),   32'd12);
    bus.start     = 1'b1;
    bus.len       = 4'd0;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("t6_hs_start_busy",  32'(bus.busy),      32'd0);
    chk("t6_hs_start_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t6_idle_stays", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mac_accum_sequencer
`default_nettype wire
